// File: rtl/imem_loader_if.sv
// Byte-stream channel feeding the instruction-memory loader.
// A byte moves on a rising edge where in_valid && in_ready; the source holds in_data stable while in_valid waits for in_ready.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian word stream into instruction RAM,
// holds the core in reset while loading, and serves combinational fetches.
module imem_loader #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic                clk,
    input  logic                rst,
    imem_loader_if.slave        stream,
    input  logic                reload,
    input  logic [31:0]         rom_addr,
    output logic [31:0]         instr,
    output logic                core_rst_n,
    output logic                load_busy,
    output logic                load_err,
    output logic [ADDR_W:0]     words_loaded,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {HDR0, HDR1, DATA, RUN, ERR} state_e;

    localparam int             DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [15:0]    FULL16 = 16'(FULL);

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic [ADDR_W:0]   wl_inc;
    logic [15:0]       hdr_len;
    logic              core_rst_n_q;
    logic              accept;
    logic              we;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic              hi_zero;
    logic              unused_addr_lsb;

    assign stream.in_ready = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
    assign accept          = stream.in_valid && stream.in_ready;
    assign hdr_len         = {stream.in_data, len_q[7:0]};
    assign wl_inc          = (wl_q == FULL) ? wl_q : wl_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        wl_d    = wl_q;
        we      = 1'b0;
        case (state_q)
            HDR0: if (accept) begin
                len_d[7:0] = stream.in_data;
                state_d    = HDR1;
            end
            HDR1: if (accept) begin
                len_d[15:8] = stream.in_data;
                if (hdr_len == 16'd0)      state_d = RUN;
                else if (hdr_len > FULL16) state_d = ERR;
                else                       state_d = DATA;
            end
            DATA: if (accept) begin
                // Shift in from the top so byte0 lands in [7:0] after four bytes.
                asm_d = {stream.in_data, asm_q[31:8]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    we   = 1'b1;
                    wl_d = wl_inc;
                    if (16'(wl_inc) == len_q) state_d = RUN;
                end
            end
            RUN, ERR: if (reload) begin
                state_d = HDR0;
                wl_d    = '0;
                cnt_d   = '0;
            end
            default: state_d = HDR0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HDR0;
            len_q        <= '0;
            cnt_q        <= '0;
            asm_q        <= '0;
            wl_q         <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            wl_q         <= wl_d;
            core_rst_n_q <= (state_d == RUN);
        end
    end

    // RAM has no reset: old contents stay behind and are masked by words_loaded.
    always_ff @(posedge clk) begin
        if (we) mem[wl_q[ADDR_W-1:0]] <= asm_d;
    end

    assign idx             = rom_addr[ADDR_W+1:2];
    assign hi_zero         = (rom_addr[31:ADDR_W+2] == '0);
    assign unused_addr_lsb = ^rom_addr[1:0];

    always_comb begin
        instr = NOP_WORD;
        if (state_q == RUN && hi_zero && ({1'b0, idx} < wl_q)) instr = mem[idx];
    end

    assign core_rst_n   = core_rst_n_q;
    assign load_busy    = stream.in_ready;
    assign load_err     = (state_q == ERR);
    assign words_loaded = wl_q;
    assign state_dbg    = state_q;

endmodule
